// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants, types and helpers for the key event arbiter
package key_pkg;

    localparam logic KEY_PRESSED = 1'b0;

    typedef struct packed {
        logic samp;
        logic deb;
    } deb_state_t;

    localparam deb_state_t DEB_RELEASED = '{samp: 1'b1, deb: 1'b1};

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// rtl/key_event_arbiter_if.sv - valid/ready event port carrying a key index
interface key_event_arbiter_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/key_rr_pick.sv
// rtl/key_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module key_rr_pick #(
    parameter int N_KEYS = 4,
    parameter int ID_W   = 2
) (
    input  logic [N_KEYS-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic              gnt_vld,
    output logic [ID_W-1:0]   gnt_id
);
    int              idx_int;
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx_int = 0;
        idx     = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            idx_int = int'(ptr) + k;
            if (idx_int >= N_KEYS) begin
                idx_int = idx_int - N_KEYS;
            end
            idx = ID_W'(idx_int);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end
endmodule

// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - shared-tick key debouncer with round-robin event issue
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int SAMPLE_DIV = 240000,
    parameter int ID_W       = id_w(N_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_KEYS-1:0]   key,
    key_event_arbiter_if.master evt,
    output logic                ovf,
    input  logic                ovf_clr
);
    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]  div_q, div_d;
    deb_state_t        dbs_q [N_KEYS];
    deb_state_t        dbs_d [N_KEYS];
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic              valid_q, valid_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              ovf_q, ovf_d;

    logic              tick;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] granted;
    logic [N_KEYS-1:0] lost;
    logic              slot_free;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;

    key_rr_pick #(.N_KEYS(N_KEYS), .ID_W(ID_W)) u_pick (
        .req     (pending_q),
        .ptr     (rr_q),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    assign tick = (div_q == CNT_W'(SAMPLE_DIV - 1));

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        dbs_d = dbs_q;
        press = '0;
        // Debounced level only moves when two consecutive ticks agree.
        for (int i = 0; i < N_KEYS; i++) begin
            if (tick) begin
                dbs_d[i].samp = sync2_q[i];
                if (sync2_q[i] == dbs_q[i].samp) begin
                    dbs_d[i].deb = sync2_q[i];
                end
                press[i] = (dbs_q[i].deb != KEY_PRESSED) && (sync2_q[i] == dbs_q[i].samp)
                           && (sync2_q[i] == KEY_PRESSED);
            end
        end
    end

    always_comb begin
        slot_free = !valid_q || evt.evt_ready;
        granted   = '0;
        valid_d   = valid_q;
        id_d      = id_q;
        rr_d      = rr_q;
        if (slot_free) begin
            if (gnt_vld) begin
                valid_d         = 1'b1;
                id_d            = gnt_id;
                granted[gnt_id] = 1'b1;
                rr_d            = (gnt_id == ID_W'(N_KEYS - 1)) ? '0 : gnt_id + 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
        // A press on a key still waiting (and not leaving this cycle) is dropped.
        lost      = press & pending_q & ~granted;
        pending_d = (pending_q & ~granted) | press;
        ovf_d     = (ovf_q & ~ovf_clr) | (|lost);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            div_q     <= '0;
            dbs_q     <= '{default: DEB_RELEASED};
            pending_q <= '0;
            rr_q      <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= key;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            dbs_q     <= dbs_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            ovf_q     <= ovf_d;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_id    = id_q;
    assign ovf           = ovf_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - directed bench with cycle-level reference model for key_event_arbiter
module tb_key_event_arbiter;
    localparam int NK  = 4;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    key_event_arbiter_if #(.ID_W(2)) evt_if ();

    key_event_arbiter #(.N_KEYS(NK), .SAMPLE_DIV(DIV), .ID_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .evt     (evt_if),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int got[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: keys sampled through two stages, a tick every DIV cycles,
    // a key counts as pressed once two successive ticks both see it low.
    int m_s1[NK], m_s2[NK], m_samp[NK], m_deb[NK], m_pend[NK];
    int m_cnt, m_rr, m_valid, m_id, m_ovf;

    always @(posedge clk) begin : model
        int press[NK];
        int grant;
        bit tick;
        if (rst) begin
            for (int i = 0; i < NK; i++) begin
                m_s1[i] = 1; m_s2[i] = 1; m_samp[i] = 1; m_deb[i] = 1; m_pend[i] = 0;
            end
            m_cnt = 0; m_rr = 0; m_valid = 0; m_id = 0; m_ovf = 0;
        end else begin
            tick = (m_cnt == DIV - 1);
            for (int i = 0; i < NK; i++) begin
                press[i] = 0;
                if (tick) begin
                    if (m_s2[i] == m_samp[i]) begin
                        if (m_deb[i] == 1 && m_s2[i] == 0) press[i] = 1;
                        m_deb[i] = m_s2[i];
                    end
                    m_samp[i] = m_s2[i];
                end
            end
            grant = -1;
            if (!m_valid || evt_if.evt_ready) begin
                for (int k = 0; k < NK; k++)
                    if (grant < 0 && m_pend[(m_rr + k) % NK] != 0) grant = (m_rr + k) % NK;
                if (grant >= 0) begin
                    m_valid = 1; m_id = grant; m_pend[grant] = 0; m_rr = (grant + 1) % NK;
                end else begin
                    m_valid = 0;
                end
            end
            if (ovf_clr) m_ovf = 0;
            for (int i = 0; i < NK; i++) begin
                if (press[i]) begin
                    if (m_pend[i] != 0) m_ovf = 1;
                    m_pend[i] = 1;
                end
            end
            for (int i = 0; i < NK; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(key[i]);
            end
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("evt_valid", int'(evt_if.evt_valid), m_valid);
            if (m_valid != 0) check("evt_id", int'(evt_if.evt_id), m_id);
            check("ovf", int'(ovf), m_ovf);
            if (!rst && evt_if.evt_valid && evt_if.evt_ready) got.push_back(int'(evt_if.evt_id));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_keys(input logic [3:0] mask, input int hold);
        key = ~mask;
        step(hold);
        key = 4'hF;
        step(14);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        got.delete();
    endtask

    task automatic expect_seq(input string name, input int n,
                              input int e0, input int e1, input int e2, input int e3);
        int  exp[4];
        bit  ok;
        string s;
        exp = '{e0, e1, e2, e3};
        ok = (got.size() == n);
        for (int i = 0; i < n && ok; i++) if (got[i] != exp[i]) ok = 1'b0;
        s = "";
        foreach (got[i]) s = {s, $sformatf(" %0d", got[i])};
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d events [%s ] expected %0d events [ %0d %0d %0d %0d ]",
                      name, got.size(), s, n, e0, e1, e2, e3);
        got.delete();
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(2);
        rst = 1'b0;
        check("reset evt_valid", int'(evt_if.evt_valid), 0);
        check("reset evt_id", int'(evt_if.evt_id), 0);
        check("reset ovf", int'(ovf), 0);
        step(10);

        // 1: one clean press of key1 gives exactly one event, release gives none
        press_keys(4'b0010, 14);
        expect_seq("t1 single press", 1, 1, 0, 0, 0);
        check("t1 ovf", int'(ovf), 0);

        // 2: a low pulse seen by only one tick, and a one-cycle low, are both rejected
        key = 4'b1011;
        step(4);
        key = 4'hF;
        step(14);
        press_keys(4'b0100, 1);
        expect_seq("t2 glitches", 0, 0, 0, 0, 0);

        // 3: simultaneous presses drain in round-robin order from pointer 0
        do_reset();
        press_keys(4'b1101, 14);
        expect_seq("t3 rr order", 3, 0, 2, 3, 0);
        press_keys(4'b0011, 14);
        expect_seq("t3 ptr wrapped to 0", 2, 0, 1, 0, 0);

        // 4: stalled consumer holds the event; a second press of a pending key overflows
        evt_if.evt_ready = 1'b0;
        press_keys(4'b0001, 14);
        press_keys(4'b0010, 14);
        check("t4 held valid", int'(evt_if.evt_valid), 1);
        check("t4 held id", int'(evt_if.evt_id), 0);
        check("t4 ovf before", int'(ovf), 0);
        press_keys(4'b0010, 14);
        check("t4 ovf set", int'(ovf), 1);
        evt_if.evt_ready = 1'b1;
        step(10);
        expect_seq("t4 drain", 2, 0, 1, 0, 0);
        check("t4 ovf sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t4 ovf cleared", int'(ovf), 0);

        // 5: reset while an event is outstanding and more are pending drops everything
        evt_if.evt_ready = 1'b0;
        press_keys(4'b0100, 14);
        press_keys(4'b1000, 14);
        press_keys(4'b1000, 14);
        check("t5 valid before rst", int'(evt_if.evt_valid), 1);
        check("t5 ovf before rst", int'(ovf), 1);
        rst = 1'b1;
        step(1);
        check("t5 valid after rst", int'(evt_if.evt_valid), 0);
        check("t5 ovf after rst", int'(ovf), 0);
        rst = 1'b0;
        evt_if.evt_ready = 1'b1;
        got.delete();
        step(30);
        expect_seq("t5 no spurious", 0, 0, 0, 0, 0);

        // 6: key3 joins behind three pending keys and is still served within four grants
        evt_if.evt_ready = 1'b0;
        press_keys(4'b0111, 14);
        press_keys(4'b1000, 14);
        evt_if.evt_ready = 1'b1;
        step(10);
        expect_seq("t6 fairness", 4, 0, 1, 2, 3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
